// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with saturating
// direction counters, execute-stage misprediction detection, a multi-cycle
// table clear and branch/mispredict statistics.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   pcf                      fetch PC; predTakenf/predHitf/predTargetf are the
//                            zero-latency lookup results for it
//   updValide, updPce,       resolved branch in execute: PC, actual outcome,
//   updTakene, updTargete    actual target
//   predTakene, predTargete  prediction that travelled with that instruction
//   mispredicte, redirectPce misprediction flag and corrected fetch PC
//   clr, busy                table clear request / clear in progress
//   brCnt, misCnt            saturating resolved-branch / mispredict counters
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pcf,
  output logic            predTakenf,
  output logic            predHitf,
  output logic [XLEN-1:0] predTargetf,
  input  logic            updValide,
  input  logic [XLEN-1:0] updPce,
  input  logic            updTakene,
  input  logic [XLEN-1:0] updTargete,
  input  logic            predTakene,
  input  logic [XLEN-1:0] predTargete,
  output logic            mispredicte,
  output logic [XLEN-1:0] redirectPce,
  input  logic            clr,
  output logic            busy,
  output logic [31:0]     brCnt,
  output logic [31:0]     misCnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t             state;
  logic [IDX_W-1:0]   clr_idx;
  logic               valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [31:0]        br_cnt;
  logic [31:0]        mis_cnt;

  logic [IDX_W-1:0]   f_idx;
  logic [TAG_W-1:0]   f_tag;
  logic [IDX_W-1:0]   u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_hit;

  assign busy   = (state == S_CLEAR);
  assign brCnt  = br_cnt;
  assign misCnt = mis_cnt;

  // Fetch-side lookup
  assign f_idx = pcf[IDX_W+1:2];
  assign f_tag = pcf[XLEN-1:IDX_W+2];

  always_comb begin
    predHitf    = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && !busy;
    predTakenf  = predHitf && ctr_q[f_idx][CTR_W-1];
    predTargetf = predTakenf ? target_q[f_idx] : pcf + XLEN'(4);
  end

  // Execute-side resolution
  assign u_idx = updPce[IDX_W+1:2];
  assign u_tag = updPce[XLEN-1:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    mispredicte = updValide &&
                  ((updTakene != predTakene) ||
                   (updTakene && (updTargete != predTargete)));
    redirectPce = updTakene ? updTargete : updPce + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      clr_idx  <= '0;
      valid_q  <= '{default: 1'b0};
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      ctr_q    <= '{default: '0};
      br_cnt   <= '0;
      mis_cnt  <= '0;
    end else begin
      // Statistics run regardless of clear activity
      if (updValide && (br_cnt != '1))
        br_cnt <= br_cnt + 32'd1;
      if (mispredicte && (mis_cnt != '1))
        mis_cnt <= mis_cnt + 32'd1;

      case (state)
        S_IDLE: begin
          if (updValide) begin
            if (u_hit) begin
              if (updTakene) begin
                if (ctr_q[u_idx] != '1)
                  ctr_q[u_idx] <= ctr_q[u_idx] + CTR_W'(1);
                target_q[u_idx] <= updTargete;
              end else if (ctr_q[u_idx] != '0) begin
                ctr_q[u_idx] <= ctr_q[u_idx] - CTR_W'(1);
              end
            end else if (updTakene) begin
              valid_q[u_idx]  <= 1'b1;
              tag_q[u_idx]    <= u_tag;
              target_q[u_idx] <= updTargete;
              ctr_q[u_idx]    <= CTR_WEAK;
            end
          end
          if (clr) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
          end
        end
        S_CLEAR: begin
          valid_q[clr_idx] <= 1'b0;
          clr_idx          <= clr_idx + IDX_W'(1);
          if (clr_idx == IDX_W'(ENTRIES - 1))
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// table-level behavioural model.
module tb_branch_predictor;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcf;
  logic        predTakenf, predHitf;
  logic [31:0] predTargetf;
  logic        updValide, updTakene, predTakene;
  logic [31:0] updPce, updTargete, predTargete;
  logic        mispredicte;
  logic [31:0] redirectPce;
  logic        clr, busy;
  logic [31:0] brCnt, misCnt;

  int n_chk  = 0;
  int n_fail = 0;

  branch_predictor #(.XLEN(32), .ENTRIES(N), .CTR_W(2)) dut (
    .clk(clk), .rst(rst), .pcf(pcf),
    .predTakenf(predTakenf), .predHitf(predHitf), .predTargetf(predTargetf),
    .updValide(updValide), .updPce(updPce), .updTakene(updTakene),
    .updTargete(updTargete), .predTakene(predTakene), .predTargete(predTargete),
    .mispredicte(mispredicte), .redirectPce(redirectPce),
    .clr(clr), .busy(busy), .brCnt(brCnt), .misCnt(misCnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  int          m_left;      // entries still to be cleared (busy while > 0)
  int          m_ptr;
  logic [31:0] m_br, m_mis;

  function automatic bit model_mis();
    return updValide && ((updTakene != predTakene) ||
                         (updTakene && updTargete != predTargete));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
      end
      m_left = 0; m_ptr = 0; m_br = 0; m_mis = 0;
    end else begin
      int unsigned ui, ut;
      if (updValide && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (model_mis() && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      if (m_left > 0) begin
        m_valid[m_ptr] = 0;
        m_ptr++;
        m_left--;
      end else begin
        if (updValide) begin
          ui = (updPce / 4) % N;
          ut = updPce / (4 * N);
          if (m_valid[ui] && m_tag[ui] == ut) begin
            if (updTakene) begin
              m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
              m_tgt[ui] = updTargete;
            end else begin
              m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
            end
          end else if (updTakene) begin
            m_valid[ui] = 1; m_tag[ui] = ut; m_tgt[ui] = updTargete; m_ctr[ui] = 2;
          end
        end
        if (clr) begin
          m_left = N;
          m_ptr  = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, all outputs against the model
  always @(negedge clk) begin
    int unsigned fi, ft;
    bit e_hit, e_tk;
    logic [31:0] e_tg;
    fi    = (pcf / 4) % N;
    ft    = pcf / (4 * N);
    e_hit = m_valid[fi] && m_tag[fi] == ft && m_left == 0;
    e_tk  = e_hit && m_ctr[fi] >= 2;
    e_tg  = e_tk ? m_tgt[fi] : pcf + 32'd4;
    chk("predHitf",    {31'b0, predHitf},    {31'b0, e_hit});
    chk("predTakenf",  {31'b0, predTakenf},  {31'b0, e_tk});
    chk("predTargetf", predTargetf, e_tg);
    chk("mispredicte", {31'b0, mispredicte}, {31'b0, model_mis()});
    chk("redirectPce", redirectPce, updTakene ? updTargete : updPce + 32'd4);
    chk("busy",        {31'b0, busy},        {31'b0, m_left > 0});
    chk("brCnt",       brCnt,  m_br);
    chk("misCnt",      misCnt, m_mis);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                     input logic ptk, input logic [31:0] ptg);
    updValide = 1; updPce = pc; updTakene = tk; updTargete = tg;
    predTakene = ptk; predTargete = ptg;
    step();
    updValide = 0;
    #1;
  endtask

  function automatic logic [31:0] rnd_pc();
    return ($urandom_range(0, 3) << 6) | ($urandom_range(0, N - 1) << 2);
  endfunction

  initial begin
    int n;
    rst = 0; pcf = 32'h100; clr = 0;
    updValide = 0; updPce = 0; updTakene = 0; updTargete = 0;
    predTakene = 0; predTargete = 0;
    repeat (3) step();
    rst = 1;
    #1;
    chk("rst_hit",    {31'b0, predHitf},   32'd0);
    chk("rst_taken",  {31'b0, predTakenf}, 32'd0);
    chk("rst_target", predTargetf, 32'h104);
    chk("rst_br",     brCnt,  32'd0);
    chk("rst_mis",    misCnt, 32'd0);

    // Allocate on taken miss
    updValide = 1; updPce = 32'h100; updTakene = 1; updTargete = 32'h200;
    predTakene = 0; predTargete = 0;
    #1;
    chk("alloc_mis",   {31'b0, mispredicte}, 32'd1);
    chk("alloc_redir", redirectPce, 32'h200);
    step();
    updValide = 0;
    #1;
    chk("alloc_hit",    {31'b0, predHitf},   32'd1);
    chk("alloc_taken",  {31'b0, predTakenf}, 32'd1);
    chk("alloc_target", predTargetf, 32'h200);
    chk("alloc_miscnt", misCnt, 32'd1);

    // Counter walk: 10 -> 01 -> 00 -> 01,10,11,11 -> 10
    upd(32'h100, 0, 32'h0, 0, 32'h0);
    chk("ctr01_hit",    {31'b0, predHitf},   32'd1);
    chk("ctr01_taken",  {31'b0, predTakenf}, 32'd0);
    chk("ctr01_target", predTargetf, 32'h104);
    upd(32'h100, 0, 32'h0, 0, 32'h0);
    chk("ctr00_taken",  {31'b0, predTakenf}, 32'd0);
    repeat (3) upd(32'h100, 1, 32'h200, 1, 32'h200);
    chk("ctr11_taken",  {31'b0, predTakenf}, 32'd1);
    upd(32'h100, 1, 32'h200, 1, 32'h200);
    upd(32'h100, 0, 32'h0, 0, 32'h0);
    chk("ctr_sat_taken",  {31'b0, predTakenf}, 32'd1);
    chk("ctr_sat_target", predTargetf, 32'h200);

    // Alias at the same index, different tag
    pcf = 32'h140;
    #1;
    chk("alias_miss", {31'b0, predHitf}, 32'd0);
    upd(32'h140, 1, 32'h300, 0, 32'h0);
    chk("alias_hit",    {31'b0, predHitf}, 32'd1);
    chk("alias_target", predTargetf, 32'h300);
    pcf = 32'h100;
    #1;
    chk("alias_evict", {31'b0, predHitf}, 32'd0);
    chk("alias_br",    brCnt,  32'd9);
    chk("alias_mis",   misCnt, 32'd2);

    // Full clear with an update during busy
    pcf = 32'h140;
    clr = 1;
    step();
    clr = 0;
    n = 0;
    repeat (40) begin
      if (!busy) break;
      n++;
      if (n == 3) begin
        chk("clr_busy_miss", {31'b0, predHitf}, 32'd0);
        updValide = 1; updPce = 32'h180; updTakene = 1; updTargete = 32'h400;
        predTakene = 0; predTargete = 0;
        clr = 1;
      end
      if (n == 4) begin
        updValide = 0; clr = 0;
        chk("clr_busy_br",  brCnt,  32'd10);
        chk("clr_busy_mis", misCnt, 32'd3);
      end
      step();
    end
    chk("clr_busy_cycles", n, 32'd16);
    #1;
    chk("clr_after_140", {31'b0, predHitf}, 32'd0);
    pcf = 32'h180;
    #1;
    chk("clr_after_180", {31'b0, predHitf}, 32'd0);

    // Reset in the middle of a clear
    clr = 1;
    step();
    clr = 0;
    repeat (4) step();
    chk("midclr_busy_pre", {31'b0, busy}, 32'd1);
    rst = 0;
    #1;
    chk("midclr_busy", {31'b0, busy}, 32'd0);
    chk("midclr_br",   brCnt, 32'd0);
    #3;
    rst = 1;
    step();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      pcf        = ($urandom_range(0, 15) == 0) ? $urandom : rnd_pc();
      updValide  = ($urandom_range(0, 2) != 0);
      updPce     = rnd_pc();
      updTakene  = $urandom_range(0, 1);
      updTargete = $urandom_range(0, 1) ? 32'h200 : ($urandom & 32'hFFFF_FFFC);
      predTakene = $urandom_range(0, 1);
      predTargete = $urandom_range(0, 1) ? updTargete : 32'h200;
      clr        = ($urandom_range(0, 60) == 0);
      step();
    end
    updValide = 0; clr = 0;
    repeat (20) step();

    // Counter saturation
    force dut.br_cnt  = 32'hFFFF_FFFF;
    force dut.mis_cnt = 32'hFFFF_FFFF;
    m_br  = 32'hFFFF_FFFF;
    m_mis = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt;
    release dut.mis_cnt;
    upd(32'h100, 1, 32'h500, 0, 32'h0);
    chk("sat_br",  brCnt,  32'hFFFF_FFFF);
    chk("sat_mis", misCnt, 32'hFFFF_FFFF);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC width.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning table depth (power of two, >=2); IDX_W=log2(ENTRIES).
REQ-003 SHALL have parameter CTR_W, default 2, meaning saturating-counter width (>=1).
REQ-004 SHALL have ports: clk  in  1  clock, single clock domain, rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: pcf  in  XLEN  fetch PC for lookup.
REQ-007 SHALL have ports: predTakenf  out  1  predicted taken; predHitf  out  1  table hit; predTargetf  out  XLEN  predicted next PC.
REQ-008 SHALL have ports: updValide  in  1  resolved branch/jump in execute; updPce  in  XLEN  its PC; updTakene  in  1  actual outcome; updTargete  in  XLEN  actual target.
REQ-009 SHALL have ports: predTakene  in  1; predTargete  in  XLEN  prediction carried down pipeline with the instruction.
REQ-010 SHALL have ports: mispredicte  out  1; redirectPce  out  XLEN  corrected fetch PC.
REQ-011 SHALL have ports: clr  in  1  table clear request; busy  out  1  clear in progress.
REQ-012 SHALL have ports: brCnt  out  32; misCnt  out  32  statistics counters.

Function
REQ-013 SHALL index with pc[IDX_W+1:2] and tag with pc[XLEN-1:IDX_W+2]; entry = valid, tag, target, counter.
REQ-014 SHALL perform lookup combinationally (zero latency): hit = valid && tag match && !busy.
REQ-015 SHALL drive predTakenf = hit && counter MSB; predTargetf = entry target if predTakenf else pcf+4 (modulo 2^XLEN).
REQ-016 SHALL write table only at rising clk when updValide && !busy; same-cycle lookup of same index sees pre-update contents.
REQ-017 SHALL on update hit: counter +1 if taken (saturate at all-ones), -1 if not taken (saturate at 0); target overwritten only when taken.
REQ-018 SHALL on update miss with updTakene=1: allocate (valid=1, new tag, target=updTargete, counter=2^(CTR_W-1), weakly taken); miss with not-taken: no change.
REQ-019 SHALL compute mispredicte = updValide && (updTakene!=predTakene || (updTakene && updTargete!=predTargete)), combinational, independent of busy.
REQ-020 SHALL drive redirectPce = updTargete if updTakene else updPce+4.
REQ-021 SHALL increment brCnt on each updValide cycle and misCnt on each mispredicte cycle, both saturating at 0xFFFFFFFF, counted during busy too.
REQ-022 SHALL implement FSM IDLE/CLEAR: IDLE + clr -> CLEAR with index 0; CLEAR invalidates one entry per cycle, index+1; after invalidating ENTRIES-1 -> IDLE.
REQ-023 SHALL hold busy=1 exactly ENTRIES cycles per clear; clr asserted while busy is ignored; clr does not affect brCnt/misCnt.

Reset
REQ-024 SHALL on rst=0 immediately (asynchronously) invalidate all entries, zero counters/targets, zero brCnt and misCnt, FSM to IDLE, busy=0, including mid-clear.
REQ-025 SHALL after reset output predTakenf=0, predHitf=0, predTargetf=pcf+4.

Verification
REQ-026 Reset: rst=0 then 1, pcf=0x100 -> predHitf=0, predTakenf=0, predTargetf=0x104, brCnt=misCnt=0.
REQ-027 Allocate: update pc=0x100 taken target 0x200, predTakene=0 -> mispredicte=1, redirectPce=0x200; next cycle pcf=0x100 -> hit=1, taken=1, target=0x200, misCnt=1.
REQ-028 Counter: after REQ-027, one not-taken update pc=0x100 -> counter 01, lookup hit=1, taken=0, target=0x104; second not-taken -> 00; three taken -> 11 (saturates, no wrap).
REQ-029 Alias: ENTRIES=16, pcf=0x140 after entry 0x100 exists -> hit=0; taken update pc=0x140 target 0x300 -> 0x140 hits, 0x100 misses.
REQ-030 Clear: one-cycle clr -> busy=1 for 16 cycles, all lookups miss, update during busy leaves table unchanged but bumps brCnt; afterwards all lookups miss.
REQ-031 Reset mid-clear and saturation: rst=0 at clear cycle 5 -> busy=0 immediately; force brCnt to 0xFFFFFFFF, updValide=1 -> stays 0xFFFFFFFF.
